mastermind_engine: RTL

MASTERMIND_ENGINE -- requirements
Module: mastermind_engine

---
 rtl/mastermind_engine_if.sv | 33 +++
 rtl/mastermind_engine.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mastermind_engine_if.sv
// Handshake bundle between a Mastermind game controller and mastermind_engine.
// The controller drives the secret/guess side; the engine drives the score side.
interface mastermind_engine_if #(
    parameter int NUM_PEGS    = 4,
    parameter int COLOR_BITS  = 2,
    parameter int MAX_GUESSES = 10
);
    localparam int CODE_W = NUM_PEGS * COLOR_BITS;
    localparam int CNT_W  = $clog2(NUM_PEGS + 1);
    localparam int GC_W   = $clog2(MAX_GUESSES + 1);

    logic              newSecret;
    logic [CODE_W-1:0] secretIn;
    logic [CODE_W-1:0] guessIn;
    logic              submit;
    logic              busy;
    logic              scoreValid;
    logic [CNT_W-1:0]  exact;
    logic [CNT_W-1:0]  partial;
    logic [GC_W-1:0]   guessCount;
    logic              won;
    logic              lost;

    modport master (
        output newSecret, secretIn, guessIn, submit,
        input  busy, scoreValid, exact, partial, guessCount, won, lost
    );

    modport slave (
        input  newSecret, secretIn, guessIn, submit,
        output busy, scoreValid, exact, partial, guessCount, won, lost
    );
endinterface

// File: rtl/mastermind_engine.sv
// Mastermind scorer: exact hits in one cycle, colour matches one colour per cycle.
// Define MM_GUESS_LIMIT_EN to enable the MAX_GUESSES limit and the LOST state.
module mastermind_engine #(
    parameter int NUM_PEGS    = 4,
    parameter int COLOR_BITS  = 2,
    parameter int MAX_GUESSES = 10
) (
    input logic                clk,
    input logic                Reset,
    mastermind_engine_if.slave mm
);
    localparam int NCOL   = 1 << COLOR_BITS;
    localparam int CODE_W = NUM_PEGS * COLOR_BITS;
    localparam int CNT_W  = $clog2(NUM_PEGS + 1);
    localparam int GC_W   = $clog2(MAX_GUESSES + 1);
    localparam int C_W    = COLOR_BITS + 1;

    typedef enum logic [2:0] {IDLE, READY, SCORE, WON, LOST} state_t;

    function automatic logic [CNT_W-1:0] color_count(input logic [CODE_W-1:0] code,
                                                     input logic [COLOR_BITS-1:0] col);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PEGS; i++)
            if (code[i*COLOR_BITS +: COLOR_BITS] == col) n = n + CNT_W'(1);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] exact_count(input logic [CODE_W-1:0] a,
                                                     input logic [CODE_W-1:0] b);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PEGS; i++)
            if (a[i*COLOR_BITS +: COLOR_BITS] == b[i*COLOR_BITS +: COLOR_BITS]) n = n + CNT_W'(1);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t            state, state_n;
    logic [CODE_W-1:0] secret_q;
    logic [CODE_W-1:0] guess_p0;
    logic [CNT_W-1:0]  exact_p0;
    logic [C_W-1:0]    c_p1;
    logic [CNT_W-1:0]  acc_p1;
    logic [CNT_W-1:0]  exact_q, partial_q;
    logic [GC_W-1:0]   guess_cnt;
    logic              score_valid, won_q;

    logic                  start, last_step, win, limit_hit;
    logic [GC_W-1:0]       gc_inc;
    logic [COLOR_BITS-1:0] col;

    assign start     = (state == READY) && mm.submit && !mm.newSecret;
    assign last_step = (state == SCORE) && (c_p1 == C_W'(NCOL));
    assign win       = (exact_p0 == CNT_W'(NUM_PEGS));
    assign gc_inc    = (guess_cnt == '1) ? guess_cnt : guess_cnt + GC_W'(1);
    assign col       = c_p1[COLOR_BITS-1:0];

`ifdef MM_GUESS_LIMIT_EN
    logic lost_q;
    assign limit_hit = (gc_inc == GC_W'(MAX_GUESSES));
    assign mm.lost   = lost_q;
`else
    assign limit_hit = 1'b0;
    assign mm.lost   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (mm.newSecret) begin
            state_n = READY;
        end else begin
            case (state)
                READY:   if (mm.submit) state_n = SCORE;
                SCORE:   if (last_step) state_n = win ? WON : (limit_hit ? LOST : READY);
                default: state_n = state;
            endcase
        end
    end

    // Stage p0: capture guess and exact hits; stage p1: per-colour match accumulation
    always_ff @(posedge clk) begin
        if (start) begin
            guess_p0 <= mm.guessIn;
            exact_p0 <= exact_count(secret_q, mm.guessIn);
            c_p1     <= '0;
            acc_p1   <= '0;
        end else if (state == SCORE && !last_step) begin
            acc_p1 <= acc_p1 + min_cnt(color_count(secret_q, col), color_count(guess_p0, col));
            c_p1   <= c_p1 + C_W'(1);
        end
    end

    // Result stage: publish score once every colour has been counted
    always_ff @(posedge clk) begin
        if (Reset) begin
            secret_q    <= '0;
            exact_q     <= '0;
            partial_q   <= '0;
            guess_cnt   <= '0;
            score_valid <= 1'b0;
            won_q       <= 1'b0;
`ifdef MM_GUESS_LIMIT_EN
            lost_q      <= 1'b0;
`endif
        end else begin
            score_valid <= 1'b0;
            if (mm.newSecret) begin
                secret_q  <= mm.secretIn;
                exact_q   <= '0;
                partial_q <= '0;
                guess_cnt <= '0;
                won_q     <= 1'b0;
`ifdef MM_GUESS_LIMIT_EN
                lost_q    <= 1'b0;
`endif
            end else if (last_step) begin
                exact_q     <= exact_p0;
                partial_q   <= acc_p1 - exact_p0;
                guess_cnt   <= gc_inc;
                score_valid <= 1'b1;
                won_q       <= win;
`ifdef MM_GUESS_LIMIT_EN
                lost_q      <= !win && limit_hit;
`endif
            end
        end
    end

    assign mm.busy       = (state == SCORE);
    assign mm.scoreValid = score_valid;
    assign mm.exact      = exact_q;
    assign mm.partial    = partial_q;
    assign mm.guessCount = guess_cnt;
    assign mm.won        = won_q;
endmodule
